microwave_timer_ctrl: RTL and testbench



---
 rtl/microwave_timer_ctrl_if.sv | 38 +++
 rtl/microwave_timer_ctrl.sv | 154 +++++++++++++++
 tb/tb_microwave_timer_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/microwave_timer_ctrl_if.sv
// ---------------------------------------------------------------------------
// microwave_timer_ctrl_if
// Signal bundle between the keypad/prescaler/door side and the microwave
// countdown controller.
//   master : drives tick, key_valid, key_digit, start, stop, clear,
//            door_closed; observes the display digits, mag_on, done and
//            the controller state.
//   slave  : the controller; the mirror image of master.
// Handshake: every command input is a one-cycle strobe sampled on the rising
// clock edge; there is no ready/backpressure, so a strobe present on an edge
// is either acted on at that edge or dropped. door_closed is a level.
// state_dbg exposes the FSM state (0 IDLE, 1 RUN, 2 PAUSE, 3 DONE).
// ---------------------------------------------------------------------------
interface microwave_timer_ctrl_if;
   logic       tick;
   logic       key_valid;
   logic [3:0] key_digit;
   logic       start;
   logic       stop;
   logic       clear;
   logic       door_closed;
   logic [3:0] min;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       mag_on;
   logic       done;
   logic [1:0] state_dbg;

   modport master (
      output tick, key_valid, key_digit, start, stop, clear, door_closed,
      input  min, sec_tens, sec_ones, mag_on, done, state_dbg
   );

   modport slave (
      input  tick, key_valid, key_digit, start, stop, clear, door_closed,
      output min, sec_tens, sec_ones, mag_on, done, state_dbg
   );
endinterface

// File: rtl/microwave_timer_ctrl.sv
// ---------------------------------------------------------------------------
// microwave_timer_ctrl
// Countdown controller for a three-digit M:ST:SO display (max 9:59).
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - microwave_timer_ctrl_if.slave: keypad entry, start/stop/clear
//          strobes, door level, 1 Hz tick in; BCD digits, mag_on, done and
//          FSM state out.
// Parameter:
//   DONE_TICKS - number of ticks done stays high before returning to IDLE.
// Event priority within a cycle: clear > stop > door open > start >
// key_valid > tick. Events that have no effect in the current state do not
// block lower-priority ones.
// ---------------------------------------------------------------------------
module microwave_timer_ctrl #(
   parameter int DONE_TICKS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   microwave_timer_ctrl_if.slave bus
);

   localparam int CW = (DONE_TICKS < 2) ? 1 : $clog2(DONE_TICKS + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    min_q, min_d;
   logic [3:0]    st_q, st_d;
   logic [3:0]    so_q, so_d;
   logic [CW-1:0] dcnt_q, dcnt_d;

   logic time_zero;
   logic time_one;
   logic key_ok;

   assign time_zero = (min_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);
   assign time_one  = (min_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd1);
   // Rejecting a shift when sec_ones > 5 keeps sec_tens a legal 0..5 digit.
   assign key_ok    = (bus.key_digit <= 4'd9) && (so_q <= 4'd5);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         min_q   <= 4'd0;
         st_q    <= 4'd0;
         so_q    <= 4'd0;
         dcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         min_q   <= min_d;
         st_q    <= st_d;
         so_q    <= so_d;
         dcnt_q  <= dcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      st_d    = st_q;
      so_d    = so_q;
      dcnt_d  = dcnt_q;

      if (bus.clear) begin
         state_d = S_IDLE;
         min_d   = 4'd0;
         st_d    = 4'd0;
         so_d    = 4'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.stop) begin
                  min_d = 4'd0;
                  st_d  = 4'd0;
                  so_d  = 4'd0;
               end else if (bus.start && bus.door_closed && !time_zero) begin
                  state_d = S_RUN;
               end else if (bus.key_valid && key_ok) begin
                  min_d = st_q;
                  st_d  = so_q;
                  so_d  = bus.key_digit;
               end
            end

            S_RUN: begin
               // Pausing wins over a coincident tick, which is dropped.
               if (bus.stop || !bus.door_closed) begin
                  state_d = S_PAUSE;
               end else if (bus.tick) begin
                  if (time_one) begin
                     state_d = S_DONE;
                     so_d    = 4'd0;
                     dcnt_d  = '0;
                  end else if (so_q != 4'd0) begin
                     so_d = so_q - 4'd1;
                  end else begin
                     so_d = 4'd9;
                     if (st_q != 4'd0) begin
                        st_d = st_q - 4'd1;
                     end else begin
                        st_d  = 4'd5;
                        min_d = min_q - 4'd1;
                     end
                  end
               end
            end

            S_PAUSE: begin
               if (bus.stop) begin
                  state_d = S_IDLE;
                  min_d   = 4'd0;
                  st_d    = 4'd0;
                  so_d    = 4'd0;
               end else if (bus.start && bus.door_closed) begin
                  state_d = S_RUN;
               end
            end

            S_DONE: begin
               min_d = 4'd0;
               st_d  = 4'd0;
               so_d  = 4'd0;
               if (bus.start || bus.stop || !bus.door_closed) begin
                  state_d = S_IDLE;
               end else if (bus.tick) begin
                  if (dcnt_q == CW'(DONE_TICKS - 1)) begin
                     state_d = S_IDLE;
                     dcnt_d  = '0;
                  end else begin
                     dcnt_d = dcnt_q + CW'(1);
                  end
               end
            end

            default: state_d = S_IDLE;
         endcase
      end
   end

   assign bus.min       = min_q;
   assign bus.sec_tens  = st_q;
   assign bus.sec_ones  = so_q;
   assign bus.mag_on    = (state_q == S_RUN);
   assign bus.done      = (state_q == S_DONE);
   assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
module tb_microwave_timer_ctrl;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef struct {
      string      name;
      logic       rst;
      logic       clr;
      logic       stp;
      logic       sta;
      logic       door;
      logic       kv;
      logic [3:0] kd;
      logic       tk;
      logic [3:0] e_min;
      logic [3:0] e_st;
      logic [3:0] e_so;
      logic       e_mag;
      logic       e_done;
      logic [1:0] e_state;
   } vec_t;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   vec_t vq[$];

   microwave_timer_ctrl_if ifc ();

   microwave_timer_ctrl #(.DONE_TICKS(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver: apply one cycle of inputs, sample #1 after the rising edge
   task automatic cycle(input logic r, input logic c, input logic sp,
                        input logic st, input logic dr, input logic kv,
                        input logic [3:0] kd, input logic tk);
      @(negedge clk);
      rst             = r;
      ifc.clear       = c;
      ifc.stop        = sp;
      ifc.start       = st;
      ifc.door_closed = dr;
      ifc.key_valid   = kv;
      ifc.key_digit   = kd;
      ifc.tick        = tk;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic dr);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, dr, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic key(input logic [3:0] d);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, d, 1'b0);
   endtask

   task automatic tick_once();
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
   endtask

   // scoreboard compare
   task automatic check(input string name, input logic [3:0] em,
                        input logic [3:0] est, input logic [3:0] eso,
                        input logic emag, input logic edone,
                        input logic [1:0] estate);
      logic [15:0] act;
      logic [15:0] exp_v;
      act   = {ifc.min, ifc.sec_tens, ifc.sec_ones, ifc.mag_on, ifc.done, ifc.state_dbg};
      exp_v = {em, est, eso, emag, edone, estate};
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h:%0h%0h mag=%b done=%b st=%0d, want %0h:%0h%0h mag=%b done=%b st=%0d",
                  name, ifc.min, ifc.sec_tens, ifc.sec_ones, ifc.mag_on, ifc.done, ifc.state_dbg,
                  em, est, eso, emag, edone, estate);
      end
   endtask

   task automatic add(input string n, input logic r, input logic c,
                      input logic sp, input logic st, input logic dr,
                      input logic kv, input logic [3:0] kd, input logic tk,
                      input logic [3:0] em, input logic [3:0] est,
                      input logic [3:0] eso, input logic emag,
                      input logic edone, input logic [1:0] estate);
      vec_t v;
      v.name = n; v.rst = r; v.clr = c; v.stp = sp; v.sta = st; v.door = dr;
      v.kv = kv; v.kd = kd; v.tk = tk; v.e_min = em; v.e_st = est; v.e_so = eso;
      v.e_mag = emag; v.e_done = edone; v.e_state = estate;
      vq.push_back(v);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      ifc.clear = 1'b0; ifc.stop = 1'b0; ifc.start = 1'b0; ifc.door_closed = 1'b1;
      ifc.key_valid = 1'b0; ifc.key_digit = 4'd0; ifc.tick = 1'b0;

      //   name               rst clr stp sta dr kv kd  tk   min st so mag dn state
      add("reset",            1, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, ST_IDLE);
      add("key1",             0, 0, 0, 0, 1, 1, 1, 0,   0, 0, 1, 0, 0, ST_IDLE);
      add("key3",             0, 0, 0, 0, 1, 1, 3, 0,   0, 1, 3, 0, 0, ST_IDLE);
      add("key0_130",         0, 0, 0, 0, 1, 1, 0, 0,   1, 3, 0, 0, 0, ST_IDLE);
      add("start_run",        0, 0, 0, 1, 1, 0, 0, 0,   1, 3, 0, 1, 0, ST_RUN);
      add("tick_129",         0, 0, 0, 0, 1, 0, 0, 1,   1, 2, 9, 1, 0, ST_RUN);
      add("key_in_run",       0, 0, 0, 0, 1, 1, 5, 0,   1, 2, 9, 1, 0, ST_RUN);
      add("stop_tick_pause",  0, 0, 1, 0, 1, 0, 0, 1,   1, 2, 9, 0, 0, ST_PAUSE);
      add("tick_in_pause",    0, 0, 0, 0, 1, 0, 0, 1,   1, 2, 9, 0, 0, ST_PAUSE);
      add("resume",           0, 0, 0, 1, 1, 0, 0, 0,   1, 2, 9, 1, 0, ST_RUN);
      add("clear_run",        0, 1, 0, 0, 1, 0, 0, 1,   0, 0, 0, 0, 0, ST_IDLE);
      add("key12_ignored",    0, 0, 0, 0, 1, 1, 12, 0,  0, 0, 0, 0, 0, ST_IDLE);
      add("key7",             0, 0, 0, 0, 1, 1, 7, 0,   0, 0, 7, 0, 0, ST_IDLE);
      add("key8_rejected",    0, 0, 0, 0, 1, 1, 8, 0,   0, 0, 7, 0, 0, ST_IDLE);
      add("stop_idle_zero",   0, 0, 1, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, ST_IDLE);
      add("start_at_zero",    0, 0, 0, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, ST_IDLE);
      add("tick_idle",        0, 0, 0, 0, 1, 0, 0, 1,   0, 0, 0, 0, 0, ST_IDLE);
      add("key2",             0, 0, 0, 0, 1, 1, 2, 0,   0, 0, 2, 0, 0, ST_IDLE);
      add("key0a",            0, 0, 0, 0, 1, 1, 0, 0,   0, 2, 0, 0, 0, ST_IDLE);
      add("key0b_200",        0, 0, 0, 0, 1, 1, 0, 0,   2, 0, 0, 0, 0, ST_IDLE);
      add("start_clear",      0, 1, 0, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, ST_IDLE);
      add("key4",             0, 0, 0, 0, 1, 1, 4, 0,   0, 0, 4, 0, 0, ST_IDLE);
      add("key5_045",         0, 0, 0, 0, 1, 1, 5, 0,   0, 4, 5, 0, 0, ST_IDLE);
      add("start_045",        0, 0, 0, 1, 1, 0, 0, 0,   0, 4, 5, 1, 0, ST_RUN);
      add("door_open_tick",   0, 0, 0, 0, 0, 0, 0, 1,   0, 4, 5, 0, 0, ST_PAUSE);
      add("start_door_open",  0, 0, 0, 1, 0, 0, 0, 0,   0, 4, 5, 0, 0, ST_PAUSE);
      add("close_start",      0, 0, 0, 1, 1, 0, 0, 0,   0, 4, 5, 1, 0, ST_RUN);
      add("tick_044",         0, 0, 0, 0, 1, 0, 0, 1,   0, 4, 4, 1, 0, ST_RUN);
      add("stop_pause",       0, 0, 1, 0, 1, 0, 0, 0,   0, 4, 4, 0, 0, ST_PAUSE);
      add("stop_pause_idle",  0, 0, 1, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, ST_IDLE);
      add("k1",               0, 0, 0, 0, 1, 1, 1, 0,   0, 0, 1, 0, 0, ST_IDLE);
      add("k0",               0, 0, 0, 0, 1, 1, 0, 0,   0, 1, 0, 0, 0, ST_IDLE);
      add("k0_100",           0, 0, 0, 0, 1, 1, 0, 0,   1, 0, 0, 0, 0, ST_IDLE);
      add("start_100",        0, 0, 0, 1, 1, 0, 0, 0,   1, 0, 0, 1, 0, ST_RUN);
      add("borrow_059",       0, 0, 0, 0, 1, 0, 0, 1,   0, 5, 9, 1, 0, ST_RUN);
      add("tick_058",         0, 0, 0, 0, 1, 0, 0, 1,   0, 5, 8, 1, 0, ST_RUN);
      add("clear2",           0, 1, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, ST_IDLE);
      add("k5",               0, 0, 0, 0, 1, 1, 5, 0,   0, 0, 5, 0, 0, ST_IDLE);
      add("k1b",              0, 0, 0, 0, 1, 1, 1, 0,   0, 5, 1, 0, 0, ST_IDLE);
      add("k7_517",           0, 0, 0, 0, 1, 1, 7, 0,   5, 1, 7, 0, 0, ST_IDLE);
      add("start_517",        0, 0, 0, 1, 1, 0, 0, 0,   5, 1, 7, 1, 0, ST_RUN);
      add("rst_tick_clear",   1, 1, 0, 0, 1, 0, 0, 1,   0, 0, 0, 0, 0, ST_IDLE);

      foreach (vq[i]) begin
         cycle(vq[i].rst, vq[i].clr, vq[i].stp, vq[i].sta, vq[i].door,
               vq[i].kv, vq[i].kd, vq[i].tk);
         check(vq[i].name, vq[i].e_min, vq[i].e_st, vq[i].e_so,
               vq[i].e_mag, vq[i].e_done, vq[i].e_state);
      end

      // Long run from 1:30 with idle gaps between ticks
      key(4'd1); key(4'd3); key(4'd0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
      check("seq_start_130", 1, 3, 0, 1, 0, ST_RUN);
      for (int i = 1; i <= 31; i++) begin
         idle(1'b1);
         idle(1'b1);
         tick_once();
         if (i == 1)  check("seq_tick1_129", 1, 2, 9, 1, 0, ST_RUN);
         if (i == 30) check("seq_tick30_100", 1, 0, 0, 1, 0, ST_RUN);
         if (i == 31) check("seq_tick31_059", 0, 5, 9, 1, 0, ST_RUN);
      end

      // Completion from 0:02 and DONE hold for exactly three ticks
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
      key(4'd2);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
      check("done_start_002", 0, 0, 2, 1, 0, ST_RUN);
      tick_once();
      check("done_tick_001", 0, 0, 1, 1, 0, ST_RUN);
      idle(1'b1);
      tick_once();
      check("done_enter", 0, 0, 0, 0, 1, ST_DONE);
      for (int i = 1; i <= 3; i++) begin
         idle(1'b1); idle(1'b1); idle(1'b1);
         check("done_hold_gap", 0, 0, 0, 0, 1, ST_DONE);
         tick_once();
         if (i < 3) check("done_hold_tick", 0, 0, 0, 0, 1, ST_DONE);
         else       check("done_exit_3rd", 0, 0, 0, 0, 0, ST_IDLE);
      end

      // Door opening in DONE returns to IDLE at once
      key(4'd1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
      tick_once();
      check("done2_enter", 0, 0, 0, 0, 1, ST_DONE);
      idle(1'b0);
      check("done2_door_exit", 0, 0, 0, 0, 0, ST_IDLE);

      // Second DONE visit starts the tick count afresh
      key(4'd1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
      tick_once();
      tick_once();
      tick_once();
      check("done3_two_ticks", 0, 0, 0, 0, 1, ST_DONE);
      tick_once();
      check("done3_exit", 0, 0, 0, 0, 0, ST_IDLE);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
